// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if -- pipeline-side memory request bus for sram_ctrl.
//
// Signals:
//   wr_en       memory write request (held until ready=1)
//   rd_en       memory read request  (held until ready=1)
//   address     32-bit byte address, bits [18:2] select the 32-bit word
//   write_data  32-bit store data
//   read_data   32-bit load data, valid while ready=1 after a read
//   ready       0 = freeze the pipeline, 1 = no access pending / completing
//
// Modports:
//   master  pipeline side (drives requests)
//   slave   controller side (sram_ctrl)
// ---------------------------------------------------------------------------
interface sram_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl -- splits a 32-bit pipeline memory access into two 16-bit SRAM
// half-accesses (low half first, then high half).
//
// FSM: IDLE -> LO -> HI -> DONE -> IDLE. ready is high in IDLE with no
// request pending and in DONE; the pipeline freezes in every other cycle.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   bus         sram_ctrl_if.slave (wr_en, rd_en, address, write_data,
//               read_data, ready)
//   sram_addr   18-bit SRAM half-word address {address[18:2], half}
//   sram_wdata  16-bit SRAM write data
//   sram_rdata  16-bit SRAM read data, sampled on the last cycle of a phase
//   sram_we_n   active-low SRAM write strobe
//   sram_oe_n   active-low SRAM output enable
//
// Parameter:
//   WAIT_CYCLES extra cycles per half-access (only with SRAM_WAIT_EN)
//
// Build option:
//   SRAM_WAIT_EN  when defined, each LO/HI phase lasts 1+WAIT_CYCLES cycles
//                 using a wait counter; otherwise each phase is one cycle and
//                 no counter exists.
// ---------------------------------------------------------------------------
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  sram_ctrl_if.slave     bus,
  output logic [17:0]    sram_addr,
  output logic [15:0]    sram_wdata,
  input  logic [15:0]    sram_rdata,
  output logic           sram_we_n,
  output logic           sram_oe_n
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] read_data_q, read_data_d;
  logic        req;
  logic        phase_last;

  assign req = bus.wr_en | bus.rd_en;

  // Address bits outside [18:2] do not take part in the SRAM address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.address[31:19], bus.address[1:0]};

`ifdef SRAM_WAIT_EN
  localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES);

  logic [WW-1:0] wait_q, wait_d;

  assign phase_last = (wait_q == WAIT_LAST);

  // Counter returns to zero on the last cycle of a phase, so every phase
  // entry starts from a cleared count.
  always_comb begin
    wait_d = '0;
    if ((state_q == S_LO || state_q == S_HI) && !phase_last)
      wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`else
  logic [31:0] unused_wait_cycles;
  assign unused_wait_cycles = WAIT_CYCLES;
  assign phase_last = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      read_data_q <= read_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    read_data_d = read_data_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LO;
          // Write wins when both requests are raised together.
          is_wr_d = bus.wr_en;
        end
      end
      S_LO: begin
        if (phase_last) begin
          state_d = S_HI;
          if (!is_wr_q) read_data_d[15:0] = sram_rdata;
        end
      end
      S_HI: begin
        if (phase_last) begin
          state_d = S_DONE;
          if (!is_wr_q) read_data_d[31:16] = sram_rdata;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic (address and data come straight from the held request)
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    bus.ready  = 1'b0;
    case (state_q)
      S_IDLE: bus.ready = !req;
      S_LO: begin
        sram_addr = {bus.address[18:2], 1'b0};
        if (is_wr_q) begin
          sram_wdata = bus.write_data[15:0];
          sram_we_n  = 1'b0;
        end else begin
          sram_oe_n  = 1'b0;
        end
      end
      S_HI: begin
        sram_addr = {bus.address[18:2], 1'b1};
        if (is_wr_q) begin
          sram_wdata = bus.write_data[31:16];
          sram_we_n  = 1'b0;
        end else begin
          sram_oe_n  = 1'b0;
        end
      end
      S_DONE:  bus.ready = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;
  localparam int WAIT = 2;
`ifdef SRAM_WAIT_EN
  localparam int PH = 1 + WAIT;
`else
  localparam int PH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata = 16'hFFFF;
  logic        sram_we_n;
  logic        sram_oe_n;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int we_cycles;

  sram_ctrl_if bus ();

  sram_ctrl #(.WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full access; entered just after a rising edge with the FSM in IDLE.
  // Checks every cycle, feeds sram_rdata (junk except on each phase's last
  // cycle). With hold=1 the request stays asserted after DONE.
  task automatic do_access(input string name, input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [17:0] exp_lo_addr,
                           input logic [15:0] lo_val, input logic [15:0] hi_val,
                           input logic [31:0] exp_rd, input bit hold);
    bit lo, hi, dn;
    bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = data;
    for (int c = 0; c <= 2*PH + 1; c++) begin
      @(negedge clk);
      lo = (c >= 1) && (c <= PH);
      hi = (c > PH) && (c <= 2*PH);
      dn = (c == 2*PH + 1);
      if (sram_we_n == 1'b0) we_cycles++;
      chk($sformatf("%s c%0d ready", name, c), {31'd0, bus.ready}, {31'd0, dn});
      chk($sformatf("%s c%0d addr", name, c), {14'd0, sram_addr},
          lo ? {14'd0, exp_lo_addr} : hi ? {14'd0, exp_lo_addr | 18'd1} : 32'd0);
      chk($sformatf("%s c%0d we_n", name, c), {31'd0, sram_we_n},
          {31'd0, !(wr && (lo || hi))});
      chk($sformatf("%s c%0d oe_n", name, c), {31'd0, sram_oe_n},
          {31'd0, !(!wr && (lo || hi))});
      chk($sformatf("%s c%0d wdata", name, c), {16'd0, sram_wdata},
          (wr && lo) ? {16'd0, data[15:0]} : (wr && hi) ? {16'd0, data[31:16]} : 32'd0);
      if (dn) chk($sformatf("%s rdata", name), bus.read_data, exp_rd);
      if (lo)      sram_rdata = (c == PH)   ? lo_val : (16'h5A5A ^ 16'(c));
      else if (hi) sram_rdata = (c == 2*PH) ? hi_val : (16'hA5A5 ^ 16'(c));
      else         sram_rdata = 16'hFFFF;
      @(posedge clk); #1;
    end
    if (!hold) begin
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus.address = '0; bus.write_data = '0;
    we_cycles = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {31'd0, bus.ready}, 32'd1);
    chk("rst we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst addr", {14'd0, sram_addr}, 32'd0);
    chk("rst rdata", bus.read_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst ready", {31'd0, bus.ready}, 32'd1);
    @(posedge clk); #1;

    // Write 0xDEADBEEF to 0x408 -> half addresses 0x00204 / 0x00205
    do_access("wr408", 1'b1, 1'b0, 32'h0000_0408, 32'hDEAD_BEEF, 18'h00204,
              16'h0000, 16'h0000, 32'h0000_0000, 1'b0);
    @(negedge clk);
    chk("idle after wr ready", {31'd0, bus.ready}, 32'd1);
    @(posedge clk); #1;

    // Read 0x408, SRAM returns BEEF then DEAD
    do_access("rd408", 1'b0, 1'b1, 32'h0000_0408, 32'h0, 18'h00204,
              16'hBEEF, 16'hDEAD, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk); #1;

    // Both requests: write wins, read_data keeps 0xDEADBEEF
    do_access("wrrd", 1'b1, 1'b1, 32'h0001_0004, 32'h1234_5678, 18'h08002,
              16'h0F0F, 16'hF0F0, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk); #1;

    // Top word, byte-offset and upper bits ignored
    do_access("rdtop", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 18'h3FFFE,
              16'h1111, 16'h2222, 32'h2222_1111, 1'b0);
    @(posedge clk); #1;

    // Reset during HI of a read: low half already captured, must be dropped
    bus.rd_en = 1'b1; bus.address = 32'h0000_0408;
    @(negedge clk);                         // IDLE, request seen
    for (int i = 1; i <= PH; i++) begin
      @(negedge clk);                       // LO cycles
      sram_rdata = (i == PH) ? 16'hCAFE : 16'h0000;
    end
    @(negedge clk);                         // first HI cycle
    chk("mid-HI oe_n", {31'd0, sram_oe_n}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("abort we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort addr", {14'd0, sram_addr}, 32'd0);
    chk("abort rdata", bus.read_data, 32'd0);
    bus.rd_en = 1'b0;
    #1;
    chk("abort ready", {31'd0, bus.ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("after abort ready", {31'd0, bus.ready}, 32'd1);
    chk("after abort rdata", bus.read_data, 32'd0);
    @(posedge clk); #1;

    // Back-to-back writes with the request held through DONE
    we_cycles = 0;
    do_access("b2b1", 1'b1, 1'b0, 32'h0000_0010, 32'hA5A5_5A5A, 18'h00008,
              16'h0, 16'h0, 32'h0, 1'b1);
    do_access("b2b2", 1'b1, 1'b0, 32'h0000_0010, 32'hA5A5_5A5A, 18'h00008,
              16'h0, 16'h0, 32'h0, 1'b0);
    chk("b2b we cycles", we_cycles, 4*PH);
    @(negedge clk);
    chk("b2b end ready", {31'd0, bus.ready}, 32'd1);
    chk("b2b end we_n", {31'd0, sram_we_n}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
